// File: rtl/quad_to_updown.sv
// Quadrature decoder driving active-low up/down count pulse trains,
// with a saturating signed queue of pending steps between decode and emit.
module quad_to_updown #(
  parameter int MODE     = 4,
  parameter int PULSE_W  = 2,
  parameter int PEND_MAX = 7
) (
  input  logic clk,
  input  logic nclr,
  input  logic a,
  input  logic b,
  input  logic err_clr,
  output logic up,
  output logic down,
  output logic dir,
  output logic err,
  output logic ovf
);

  localparam int PB = $clog2(PEND_MAX + 1) + 1;
  localparam int CW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
  localparam logic [CW-1:0] CLAST = CW'(PULSE_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    GAP
  } st_t;

  st_t st_q, st_d;

  logic [1:0] s1_q, s2_q, prev_q, prime_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic signed [PB-1:0] pend_q, pend_d;

  logic up_q, up_d;
  logic down_q, down_d;
  logic dir_q, dir_d;
  logic err_q, err_d;
  logic ovf_q, ovf_d;

  logic primed, fwd, rev, ill;
  logic qual_up, qual_dn, ev_up, ev_dn;
  logic pos, neg, deq, drop;
  int base, net;

  // Forward successor of ab is {b, ~a}: 00->01->11->10->00
  always_comb begin
    primed  = prime_q == 2'd3;
    fwd     = s2_q == {prev_q[0], ~prev_q[1]};
    rev     = prev_q == {s2_q[0], ~s2_q[1]};
    ill     = s2_q == ~prev_q;
    qual_up = 1'b1;
    qual_dn = 1'b1;
    if (MODE == 2) begin
      qual_up = s2_q[1] ^ prev_q[1];
      qual_dn = s2_q[1] ^ prev_q[1];
    end else if (MODE == 1) begin
      qual_up = (prev_q == 2'b01) && (s2_q == 2'b11);
      qual_dn = (prev_q == 2'b11) && (s2_q == 2'b01);
    end
    ev_up = primed & fwd & qual_up;
    ev_dn = primed & rev & qual_dn;
  end

  always_comb begin
    pos  = !pend_q[PB-1] && (pend_q != '0);
    neg  = pend_q[PB-1];
    deq  = (st_q == IDLE) && (pos || neg);
    base = int'(pend_q);
    if (deq) begin
      base = pos ? base - 1 : base + 1;
    end
    net    = base + int'(ev_up) - int'(ev_dn);
    drop   = (net > PEND_MAX) || (net < -PEND_MAX);
    pend_d = drop ? PB'(base) : PB'(net);
    err_d  = (err_q & ~err_clr) | (primed & ill);
    ovf_d  = (ovf_q & ~err_clr) | drop;
  end

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    up_d   = up_q;
    down_d = down_q;
    dir_d  = dir_q;
    unique case (st_q)
      IDLE: begin
        cnt_d = '0;
        if (pos) begin
          up_d  = 1'b0;
          dir_d = 1'b1;
          st_d  = LOW;
        end else if (neg) begin
          down_d = 1'b0;
          dir_d  = 1'b0;
          st_d   = LOW;
        end
      end
      LOW: begin
        if (cnt_q == CLAST) begin
          up_d   = 1'b1;
          down_d = 1'b1;
          cnt_d  = '0;
          st_d   = GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == CLAST) begin
          cnt_d = '0;
          st_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        up_d   = 1'b1;
        down_d = 1'b1;
        cnt_d  = '0;
        st_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      s1_q    <= '0;
      s2_q    <= '0;
      prev_q  <= '0;
      prime_q <= '0;
      pend_q  <= '0;
      st_q    <= IDLE;
      cnt_q   <= '0;
      up_q    <= 1'b1;
      down_q  <= 1'b1;
      dir_q   <= 1'b1;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      s1_q <= {a, b};
      s2_q <= s1_q;
      if (!primed) prime_q <= prime_q + 2'd1;
      if (prime_q[1]) prev_q <= s2_q;
      pend_q <= pend_d;
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      up_q   <= up_d;
      down_q <= down_d;
      dir_q  <= dir_d;
      err_q  <= err_d;
      ovf_q  <= ovf_d;
    end
  end

  assign up   = up_q;
  assign down = down_q;
  assign dir  = dir_q;
  assign err  = err_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_quad_to_updown.sv
// Directed bench for quad_to_updown: three instances
// (x4/PW2, x4/PW4, x1/PW2) share the encoder inputs.
module tb_quad_to_updown;

  logic clk;
  logic nclr;
  logic a;
  logic b;
  logic err_clr;
  logic [2:0] upw, dnw, dirw, errw, ovfw;

  int n_chk;
  int n_fail;
  int ucnt[3];
  int dcnt[3];
  int werr[3];
  int urun[3];
  int drun[3];

  quad_to_updown #(.MODE(4), .PULSE_W(2), .PEND_MAX(7)) u0 (
    .clk(clk), .nclr(nclr), .a(a), .b(b), .err_clr(err_clr),
    .up(upw[0]), .down(dnw[0]), .dir(dirw[0]),
    .err(errw[0]), .ovf(ovfw[0])
  );

  quad_to_updown #(.MODE(4), .PULSE_W(4), .PEND_MAX(7)) u1 (
    .clk(clk), .nclr(nclr), .a(a), .b(b), .err_clr(err_clr),
    .up(upw[1]), .down(dnw[1]), .dir(dirw[1]),
    .err(errw[1]), .ovf(ovfw[1])
  );

  quad_to_updown #(.MODE(1), .PULSE_W(2), .PEND_MAX(7)) u2 (
    .clk(clk), .nclr(nclr), .a(a), .b(b), .err_clr(err_clr),
    .up(upw[2]), .down(dnw[2]), .dir(dirw[2]),
    .err(errw[2]), .ovf(ovfw[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pwv(int i);
    return (i == 1) ? 4 : 2;
  endfunction

  function automatic logic [1:0] fnext(logic [1:0] v);
    return {v[0], ~v[1]};
  endfunction

  function automatic logic [1:0] fprev(logic [1:0] v);
    return {~v[0], v[1]};
  endfunction

  // Pulse counter, width and overlap watcher; truncated pulses under reset ignored
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!nclr) begin
        urun[i] <= 0;
        drun[i] <= 0;
      end else begin
        if (!upw[i]) urun[i] <= urun[i] + 1;
        else if (urun[i] != 0) begin
          ucnt[i] <= ucnt[i] + 1;
          urun[i] <= 0;
          if (urun[i] != pwv(i)) werr[i] <= werr[i] + 1;
        end
        if (!dnw[i]) drun[i] <= drun[i] + 1;
        else if (drun[i] != 0) begin
          dcnt[i] <= dcnt[i] + 1;
          drun[i] <= 0;
          if (drun[i] != pwv(i)) werr[i] <= werr[i] + 1;
        end
        if (!upw[i] && !dnw[i]) werr[i] <= werr[i] + 1;
      end
    end
  end

  task automatic test_reset;
    a = 1'b1;
    b = 1'b1;
    err_clr = 1'b0;
    #1 nclr = 1'b0;
    repeat (5) begin
      @(negedge clk);
      n_chk++;
      if ({upw[0], dnw[0], dirw[0], errw[0], ovfw[0]} !== 5'b11100) begin
        n_fail++;
        $display("FAIL reset_hold: got %b expected 11100",
                 {upw[0], dnw[0], dirw[0], errw[0], ovfw[0]});
      end
    end
    nclr = 1'b1;
    repeat (10) begin
      @(negedge clk);
      n_chk++;
      if ({upw[0], dnw[0], dirw[0], errw[0], ovfw[0]} !== 5'b11100) begin
        n_fail++;
        $display("FAIL reset_prime: got %b expected 11100",
                 {upw[0], dnw[0], dirw[0], errw[0], ovfw[0]});
      end
    end
    n_chk++;
    if (ucnt[0] + dcnt[0] + ucnt[1] + dcnt[1] + ucnt[2] + dcnt[2] != 0) begin
      n_fail++;
      $display("FAIL reset_nopulse: got %0d pulses expected 0",
               ucnt[0] + dcnt[0] + ucnt[1] + dcnt[1] + ucnt[2] + dcnt[2]);
    end
  endtask

  task automatic test_forward;
    int us, ds;
    us = ucnt[0];
    ds = dcnt[0];
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      {a, b} = fnext({a, b});
      repeat (3) @(negedge clk);
      n_chk++;
      if (upw[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL fwd_e2_%0d: up=%b expected 1", k, upw[0]);
      end
      @(negedge clk);
      n_chk++;
      if (upw[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL fwd_e3_%0d: up=%b expected 0", k, upw[0]);
      end
      @(negedge clk);
      n_chk++;
      if (upw[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL fwd_e4_%0d: up=%b expected 0", k, upw[0]);
      end
      @(negedge clk);
      n_chk++;
      if (upw[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL fwd_e5_%0d: up=%b expected 1", k, upw[0]);
      end
      repeat (3) @(negedge clk);
    end
    n_chk++;
    if (ucnt[0] - us != 4) begin
      n_fail++;
      $display("FAIL fwd_upcnt: got %0d expected 4", ucnt[0] - us);
    end
    n_chk++;
    if (dcnt[0] - ds != 0) begin
      n_fail++;
      $display("FAIL fwd_dncnt: got %0d expected 0", dcnt[0] - ds);
    end
    n_chk++;
    if (dirw[0] !== 1'b1 || werr[0] != 0) begin
      n_fail++;
      $display("FAIL fwd_dir_width: dir=%b werr=%0d expected 1/0",
               dirw[0], werr[0]);
    end
  endtask

  task automatic test_overflow;
    int us, ds;
    us = ucnt[1];
    ds = dcnt[1];
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      {a, b} = fprev({a, b});
      @(negedge clk);
    end
    repeat (130) @(negedge clk);
    n_chk++;
    if (ovfw[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set: got %b expected 1", ovfw[1]);
    end
    n_chk++;
    if (dcnt[1] - ds != 10) begin
      n_fail++;
      $display("FAIL ovf_dncnt: got %0d expected 10", dcnt[1] - ds);
    end
    n_chk++;
    if (ucnt[1] - us != 0 || werr[1] != 0) begin
      n_fail++;
      $display("FAIL ovf_upcnt_width: up=%0d werr=%0d expected 0/0",
               ucnt[1] - us, werr[1]);
    end
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_chk++;
    if (ovfw[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clr: got %b expected 0", ovfw[1]);
    end
  endtask

  task automatic test_illegal;
    int us, ds;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      {a, b} = fnext({a, b});
      repeat (10) @(negedge clk);
    end
    us = ucnt[0];
    ds = dcnt[0];
    @(negedge clk);
    {a, b} = 2'b11;
    repeat (2) @(negedge clk);
    n_chk++;
    if (errw[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL ill_e1: err=%b expected 0", errw[0]);
    end
    @(negedge clk);
    n_chk++;
    if (errw[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL ill_e2: err=%b expected 1", errw[0]);
    end
    repeat (10) @(negedge clk);
    n_chk++;
    if (ucnt[0] != us || dcnt[0] != ds) begin
      n_fail++;
      $display("FAIL ill_nopulse: got %0d/%0d expected 0/0",
               ucnt[0] - us, dcnt[0] - ds);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_chk++;
    if (errw[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL ill_clr: err=%b expected 0", errw[0]);
    end
    {a, b} = 2'b00;
    repeat (2) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_chk++;
    if (errw[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL ill_setwins: err=%b expected 1", errw[0]);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_chk++;
    if (errw[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL ill_clr2: err=%b expected 0", errw[0]);
    end
  endtask

  task automatic test_back_to_back;
    int us, ds;
    logic [1:0] seq [4];
    seq = '{2'b01, 2'b11, 2'b01, 2'b00};
    us = ucnt[1];
    ds = dcnt[1];
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      {a, b} = seq[k];
      @(negedge clk);
    end
    repeat (40) @(negedge clk);
    n_chk++;
    if (ucnt[1] - us != 1 || dcnt[1] - ds != 1) begin
      n_fail++;
      $display("FAIL rev_counts: got %0d/%0d expected 1/1",
               ucnt[1] - us, dcnt[1] - ds);
    end
    n_chk++;
    if (werr[1] != 0) begin
      n_fail++;
      $display("FAIL rev_overlap_width: got %0d expected 0", werr[1]);
    end
    n_chk++;
    if (u1.pend_q !== 4'sd0) begin
      n_fail++;
      $display("FAIL rev_pend: got %0d expected 0", u1.pend_q);
    end
  endtask

  task automatic test_x1_reset;
    int us, ds;
    us = ucnt[2];
    ds = dcnt[2];
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      {a, b} = fnext({a, b});
      repeat (9) @(negedge clk);
    end
    n_chk++;
    if (ucnt[2] - us != 1 || dcnt[2] - ds != 0) begin
      n_fail++;
      $display("FAIL x1_counts: got %0d/%0d expected 1/0",
               ucnt[2] - us, dcnt[2] - ds);
    end
    @(negedge clk);
    {a, b} = 2'b01;
    repeat (10) @(negedge clk);
    {a, b} = 2'b11;
    repeat (4) @(negedge clk);
    n_chk++;
    if (upw[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL x1_pulse_low: up=%b expected 0", upw[2]);
    end
    #2 nclr = 1'b0;
    #1;
    n_chk++;
    if (upw[2] !== 1'b1 || dirw[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL x1_async_rst: up=%b dir=%b expected 1/1",
               upw[2], dirw[2]);
    end
    repeat (3) @(negedge clk);
    nclr = 1'b1;
    repeat (12) @(negedge clk);
    n_chk++;
    if (ucnt[2] - us != 1 || upw[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL x1_after_rst: cnt=%0d up=%b expected 1/1",
               ucnt[2] - us, upw[2]);
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    nclr = 1'b1;
    a = 1'b0;
    b = 1'b0;
    err_clr = 1'b0;
    test_reset();
    test_forward();
    test_overflow();
    test_illegal();
    test_back_to_back();
    test_x1_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
